io_tile_config_chain: RTL and testbench

- Parametrised configuration chain for IO tiles, generalised from the fixed 36-bit tile config shift register.
- Serial frame loads into a shift stage, then commits atomically to a shadow register that drives the tile's config bus.
- Adds optional even parity, bit-count checking, commit handshake and serial readback of the active configuration.
- Sits in each IO tile top, daisy-chained through config_in/config_out.

---
 rtl/io_tile_config_pkg.sv | 18 +
 rtl/config_shift_stage.sv | 58 +++++
 rtl/io_tile_config_chain.sv | 84 ++++++++
 tb/tb_io_tile_config_chain.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/io_tile_config_pkg.sv
// Shared definitions for the IO tile configuration chain.
//   frame_width() : serial frame length = config bits + optional parity bit
//   cnt_state_e   : occupancy of the shift stage (EMPTY / PARTIAL / FULL)
package io_tile_config_pkg;

  localparam int DEFAULT_CONFIG_WIDTH = 36;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } cnt_state_e;

  function automatic int frame_width(input int width, input int parity_en);
    return width + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/config_shift_stage.sv
// Serial shift stage of the configuration chain.
//   clk, rst_n    : clock, async active-low reset
//   shift_en, din : shift one bit in at the LSB (first bit ends at the MSB)
//   load_en       : parallel load of load_value (readback path)
//   clear_count   : return the bit counter to EMPTY (after an accepted commit)
//   shift_q       : stage contents; shift_q[FRAME-1] is the chain output
//   parity        : XOR of all bits currently held in the stage
//   state         : counter occupancy
module config_shift_stage
  import io_tile_config_pkg::*;
#(
  parameter int FRAME = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             din,
  input  logic             load_en,
  input  logic             clear_count,
  input  logic [FRAME-1:0] load_value,
  output logic [FRAME-1:0] shift_q,
  output logic             parity,
  output cnt_state_e       state
);

  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME);

  logic [CW-1:0] count;

  // Parity is maintained incrementally: the bit entering is added and the
  // bit leaving at the MSB is removed, so it always equals the XOR of the
  // stage contents, including during overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      parity  <= 1'b0;
      count   <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[FRAME-2:0], din};
      parity  <= parity ^ din ^ shift_q[FRAME-1];
      if (count != FULL_CNT) count <= count + 1'b1;
    end else if (load_en) begin
      shift_q <= load_value;
      parity  <= 1'b0;
      count   <= FULL_CNT;
    end else if (clear_count) begin
      count <= '0;
    end
  end

  always_comb begin
    state = PARTIAL;
    if (count == '0)           state = EMPTY;
    else if (count == FULL_CNT) state = FULL;
  end

endmodule

// File: rtl/io_tile_config_chain.sv
// IO tile configuration chain: serial frame loads into a shift stage and is
// committed atomically to a shadow register driving the tile config bus.
//   config_clock, config_nreset : clock, async active-low reset
//   config_in / config_out      : daisy-chain serial data
//   config_enable               : shift enable (highest priority)
//   config_commit               : commit shift stage to shadow
//   config_readback             : reload shift stage from shadow
//   config_data                 : active configuration
//   config_valid / config_error : committed-frame flag / sticky reject flag
module io_tile_config_chain
  import io_tile_config_pkg::*;
#(
  parameter int                        CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
  parameter int                        PARITY_EN    = 1,
  parameter logic [CONFIG_WIDTH-1:0]   CONFIG_RESET = '0
) (
  input  logic                    config_clock,
  input  logic                    config_nreset,
  input  logic                    config_in,
  input  logic                    config_enable,
  input  logic                    config_commit,
  input  logic                    config_readback,
  output logic                    config_out,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    config_valid,
  output logic                    config_error
);

  localparam int FRAME = frame_width(CONFIG_WIDTH, PARITY_EN);
  localparam int PB    = FRAME - CONFIG_WIDTH;

  logic [FRAME-1:0] shift_q;
  logic [FRAME-1:0] load_value;
  logic             parity;
  cnt_state_e       state;
  logic             commit_ok, commit_rej, readback_go;
  logic             unused_bits;

  // Enable beats commit beats readback.
  assign commit_ok   = config_commit && !config_enable && (state == FULL) &&
                       ((PARITY_EN == 0) || !parity);
  assign commit_rej  = config_commit && !commit_ok;
  assign readback_go = config_readback && !config_enable && !config_commit;

  // Readback frame carries a freshly computed parity bit so that an
  // immediate commit of the reloaded stage is accepted.
  if (PARITY_EN != 0) begin : g_par
    assign load_value = {config_data, ^config_data};
  end else begin : g_nopar
    assign load_value = config_data;
  end

  config_shift_stage #(.FRAME(FRAME)) u_stage (
    .clk        (config_clock),
    .rst_n      (config_nreset),
    .shift_en   (config_enable),
    .din        (config_in),
    .load_en    (readback_go),
    .clear_count(commit_ok),
    .load_value (load_value),
    .shift_q    (shift_q),
    .parity     (parity),
    .state      (state)
  );

  assign config_out  = shift_q[FRAME-1];
  // The parity bit itself is only consumed through the running parity.
  assign unused_bits = shift_q[0];

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      config_data  <= CONFIG_RESET;
      config_valid <= 1'b0;
      config_error <= 1'b0;
    end else if (commit_ok) begin
      config_data  <= shift_q[FRAME-1:PB];
      config_valid <= 1'b1;
      config_error <= 1'b0;
    end else if (commit_rej) begin
      config_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_tile_config_chain.sv
module tb_io_tile_config_chain;
  import io_tile_config_pkg::*;

  localparam int W     = 8;
  localparam int PE    = 1;
  localparam int FRAME = W + PE;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         cin = 1'b0, en = 1'b0, cm = 1'b0, rb = 1'b0;
  logic         cout;
  logic [W-1:0] cdata;
  logic         cvalid, cerr;

  always #5 clk = ~clk;

  io_tile_config_chain #(.CONFIG_WIDTH(W), .PARITY_EN(PE), .CONFIG_RESET('0)) dut (
    .config_clock   (clk),
    .config_nreset  (nrst),
    .config_in      (cin),
    .config_enable  (en),
    .config_commit  (cm),
    .config_readback(rb),
    .config_out     (cout),
    .config_data    (cdata),
    .config_valid   (cvalid),
    .config_error   (cerr)
  );

  typedef struct {
    bit         out;
    bit [W-1:0] data;
    bit         valid;
    bit         err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the stage is a queue of the last FRAME bits, oldest first.
  bit         hist[$];
  int         cnt;
  bit [W-1:0] m_data;
  bit         m_valid, m_err;
  int         total = 0, bad = 0, ncyc = 0;

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < FRAME; i++) hist.push_back(1'b0);
    cnt = 0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.out = hist[0]; e.data = m_data; e.valid = m_valid; e.err = m_err;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    total++;
    if (cout !== e.out || cdata !== e.data || cvalid !== e.valid || cerr !== e.err) begin
      bad++;
      $display("FAIL %s: got out=%b data=%h valid=%b err=%b, want out=%b data=%h valid=%b err=%b",
               name, cout, cdata, cvalid, cerr, e.out, e.data, e.valid, e.err);
    end
  endtask

  // One clock cycle of stimulus; the model is stepped on the same edge and
  // the expected post-edge outputs are queued for the monitor.
  task automatic cycle(input bit e_i, input bit d_i, input bit c_i, input bit r_i);
    int ones;
    @(negedge clk);
    en = e_i; cin = d_i; cm = c_i; rb = r_i;
    @(posedge clk);
    if (e_i) begin
      hist.push_back(d_i);
      void'(hist.pop_front());
      if (cnt < FRAME) cnt++;
      if (c_i) m_err = 1'b1;
    end else if (c_i) begin
      ones = 0;
      foreach (hist[i]) ones += hist[i];
      if (cnt == FRAME && (ones % 2) == 0) begin
        for (int i = 0; i < W; i++) m_data[W-1-i] = hist[i];
        m_valid = 1'b1; m_err = 1'b0; cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (r_i) begin
      hist = {};
      ones = 0;
      for (int i = W-1; i >= 0; i--) begin hist.push_back(m_data[i]); ones += m_data[i]; end
      hist.push_back(ones % 2);
      cnt = FRAME;
    end
    exp_q.push_back(cur_exp());
  endtask

  task automatic send_frame(input bit [W-1:0] b, input bit bad_par);
    int ones = 0;
    for (int i = W-1; i >= 0; i--) begin cycle(1, b[i], 0, 0); ones += b[i]; end
    cycle(1, (ones % 2) ^ bad_par, 0, 0);
  endtask

  // Monitor: compares the oldest pending expectation away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        ncyc++;
        check($sformatf("cycle%0d", ncyc), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [W-1:0] pat;
    model_reset();
    #1 check("reset_state", cur_exp());
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Nominal 0xA5 load and commit
    send_frame(8'hA5, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    // Underrun
    repeat (5) cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);

    // Parity failure, then a good 0x3C frame
    send_frame(8'hA5, 1);
    cycle(0, 0, 1, 0);
    send_frame(8'h3C, 0);
    cycle(0, 0, 1, 0);

    // Overrun / daisy: three extra leading bits
    cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
    send_frame(8'hA5, 0);
    cycle(0, 0, 1, 0);

    // Readback of 0xA5, then shift it out
    cycle(0, 0, 0, 1);
    repeat (FRAME) cycle(1, 0, 0, 0);
    // readback again and immediate commit re-applies
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);

    // Collisions
    send_frame(8'h5A, 0);
    cycle(1, 1, 1, 0);       // commit+enable: shift, reject
    cycle(1, 0, 0, 1);       // readback+enable: ignored
    cycle(0, 0, 1, 1);       // commit+readback: commit only
    cycle(0, 0, 0, 1);

    // Randomised frames with occasional corrupt parity
    for (int k = 0; k < 20; k++) begin
      pat = W'($urandom);
      send_frame(pat, ($urandom_range(0, 3) == 0));
      cycle(0, 0, 1, $urandom_range(0, 1));
    end

    // Randomised control mix
    for (int k = 0; k < 300; k++)
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1),
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);

    // Async reset after 4 shifts
    send_frame(8'hC3, 0);
    cycle(0, 0, 1, 0);
    repeat (4) cycle(1, 1, 0, 0);
    @(negedge clk);
    en = 0; cm = 0; rb = 0;
    #2 nrst = 1'b0;
    #1 model_reset();
    check("async_reset", cur_exp());
    @(negedge clk);
    check("reset_hold", cur_exp());
    nrst = 1'b1;
    send_frame(8'h81, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
